sequential_divider: RTL

//  Multi-cycle restoring divider; arithmetic inverse of the 4x4 array multiplier.

---
 rtl/sequential_divider.sv | 106 ++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, start/ready/done handshake.
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               ready,
    output logic               done,
    output logic               divzero,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(DW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [DW-1:0]    shreg;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   step;
    logic             step_qbit;
    logic [WIDTH-1:0] step_rem;

    // One restoring step; the trial value needs WIDTH+1 bits because the
    // shifted partial remainder can momentarily exceed WIDTH bits.
    // Returns {quotient bit, new partial remainder}.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH-1:0] part,
        input logic             msb,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] p;
        p = {part, msb};
        if (p >= {1'b0, dvs}) begin
            p = p - {1'b0, dvs};
            return {1'b1, p[WIDTH-1:0]};
        end
        return {1'b0, p[WIDTH-1:0]};
    endfunction

    assign step      = restore_step(partial, shreg[DW-1], divisor_q);
    assign step_qbit = step[WIDTH];
    assign step_rem  = step[WIDTH-1:0];
    assign ready     = (state != ST_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            divzero   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            count     <= '0;
            shreg     <= '0;
            partial   <= '0;
            divisor_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Division by zero resolves immediately with a saturated quotient.
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            divzero   <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                        end else begin
                            state     <= ST_BUSY;
                            done      <= 1'b0;
                            divzero   <= 1'b0;
                            shreg     <= dividend;
                            partial   <= '0;
                            divisor_q <= divisor;
                            count     <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
                    shreg   <= {shreg[DW-2:0], step_qbit};
                    partial <= step_rem;
                    count   <= count + 1'b1;
                    if (count == CNT_W'(DW - 1)) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        quotient  <= {shreg[DW-2:0], step_qbit};
                        remainder <= step_rem;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
